// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
//   Definitions shared by the Morse transmitter (morse_tx) and receiver
//   (morseio):
//     - morse_state_e : sequencer state encoding (IDLE, MARK, SPACE, CGAP)
//     - DEF_*         : default timing constants in ms, default clock in kHz
//     - TIMER_W       : width of the element timer
//     - morse_start_t : bundle of everything needed to launch one character
//     - ms_to_cyc()   : milliseconds to clock cycles, never less than 1
//     - clamp_len()   : limits an element count to MAX_ELEMS
// -----------------------------------------------------------------------------
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2,
        CGAP  = 2'd3
    } morse_state_e;

    localparam int unsigned DEF_CLK_KHZ     = 10;
    localparam int unsigned DEF_DOT_MS      = 100;
    localparam int unsigned DEF_DASH_MS     = 400;
    localparam int unsigned DEF_GAP_MS      = 100;
    localparam int unsigned DEF_CHAR_GAP_MS = 700;

    localparam int unsigned TIMER_W   = 32;
    localparam int unsigned MAX_ELEMS = 8;

    typedef struct packed {
        morse_state_e         state;
        logic [7:0]           code;
        logic [2:0]           idx;
        logic [TIMER_W-1:0]   load_value;
    } morse_start_t;

    // A zero product (e.g. a 0 ms setting) would make a state last zero
    // cycles, which the sequencer cannot express; force it to one cycle.
    function automatic logic [TIMER_W-1:0] ms_to_cyc(input int unsigned ms,
                                                     input int unsigned khz);
        logic [TIMER_W-1:0] cyc;
        cyc = TIMER_W'(ms * khz);
        if (cyc == '0) begin
            cyc = TIMER_W'(1);
        end
        return cyc;
    endfunction

    function automatic logic [3:0] clamp_len(input logic [3:0] length);
        return (length > 4'(MAX_ELEMS)) ? 4'(MAX_ELEMS) : length;
    endfunction

endpackage

// File: rtl/morse_timer.sv
// -----------------------------------------------------------------------------
// morse_timer
//   Loadable down-counter that times each MARK / SPACE / CGAP interval.
//   Loading N makes expire assert N cycles later (N+1 cycles of the state
//   that loaded it are therefore obtained by loading the duration minus one).
//   The counter stops at zero.
//
//   Ports
//     clk         in   clock, rising edge
//     rst         in   synchronous active-high reset, clears the count
//     load        in   load load_value this cycle (has priority over counting)
//     load_value  in   TIMER_W-bit value to load
//     value       out  current count
//     expire      out  count is zero
// -----------------------------------------------------------------------------
module morse_timer
    import morse_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    output logic [TIMER_W-1:0] value,
    output logic               expire
);

    logic [TIMER_W-1:0] value_q;
    logic [TIMER_W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_value;
        end else if (value_q != '0) begin
            value_d = value_q - TIMER_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value  = value_q;
    assign expire = (value_q == '0);

endmodule

// File: rtl/morse_tx.sv
// -----------------------------------------------------------------------------
// morse_tx
//   Keys one Morse character at a time onto morseout. A character is a count
//   of elements (in_length, clamped to 8) and a code word (in_code) holding
//   one bit per element, 0 = dot, 1 = dash, sent MSB-first starting at bit
//   length-1. Each mark is followed by an inter-element space, except the
//   last, which is followed by the character gap; done pulses on the last
//   gap cycle. A length of 0 sends only the character gap (word space).
//
//   Optional build macro MORSE_TX_SKID_EN: adds a one-entry holding register
//   so the next character can be accepted while one is being sent, and
//   chains characters back-to-back with no idle cycle between them.
//
//   Parameters
//     CLK_KHZ, DOT_MS, DASH_MS, GAP_MS, CHAR_GAP_MS  timing, see morse_pkg
//
//   Ports
//     clk        in   clock, rising edge
//     rst        in   synchronous active-high reset, aborts any character
//     in_valid   in   character offered
//     in_ready   out  character can be accepted this cycle
//     in_length  in   element count 0..15 (values above 8 treated as 8)
//     in_code    in   element bits, first at in_length-1, last at bit 0
//     morseout   out  keyed line, 1 = mark
//     busy       out  sequencer not idle
//     done       out  one-cycle pulse at the end of each character gap
// -----------------------------------------------------------------------------
module morse_tx
    import morse_pkg::*;
#(
    parameter int unsigned CLK_KHZ     = DEF_CLK_KHZ,
    parameter int unsigned DOT_MS      = DEF_DOT_MS,
    parameter int unsigned DASH_MS     = DEF_DASH_MS,
    parameter int unsigned GAP_MS      = DEF_GAP_MS,
    parameter int unsigned CHAR_GAP_MS = DEF_CHAR_GAP_MS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_length,
    input  logic [7:0] in_code,
    output logic       morseout,
    output logic       busy,
    output logic       done
);

    localparam logic [TIMER_W-1:0] DOT_CYC      = ms_to_cyc(DOT_MS, CLK_KHZ);
    localparam logic [TIMER_W-1:0] DASH_CYC     = ms_to_cyc(DASH_MS, CLK_KHZ);
    localparam logic [TIMER_W-1:0] GAP_CYC      = ms_to_cyc(GAP_MS, CLK_KHZ);
    localparam logic [TIMER_W-1:0] CHAR_GAP_CYC = ms_to_cyc(CHAR_GAP_MS, CLK_KHZ);

    // The timer expires N cycles after a load of N, and the loading cycle is
    // the last cycle of the previous state, so each interval loads length-1.
    localparam logic [TIMER_W-1:0] ONE         = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] DOT_LD      = DOT_CYC - ONE;
    localparam logic [TIMER_W-1:0] DASH_LD     = DASH_CYC - ONE;
    localparam logic [TIMER_W-1:0] GAP_LD      = GAP_CYC - ONE;
    localparam logic [TIMER_W-1:0] CHAR_GAP_LD = CHAR_GAP_CYC - ONE;

    function automatic logic [TIMER_W-1:0] mark_load(input logic is_dash);
        return is_dash ? DASH_LD : DOT_LD;
    endfunction

    // Bits at or above the clamped length are zeroed so they can never be
    // selected later.
    function automatic morse_start_t start_char(input logic [3:0] length,
                                                 input logic [7:0] code);
        morse_start_t s;
        logic [3:0]   len_c;
        logic [7:0]   mask;
        len_c = clamp_len(length);
        mask  = 8'((9'd1 << len_c) - 9'd1);
        s.code = code & mask;
        if (len_c == 4'd0) begin
            s.state      = CGAP;
            s.idx        = 3'd0;
            s.load_value = CHAR_GAP_LD;
        end else begin
            s.state      = MARK;
            s.idx        = 3'(len_c - 4'd1);
            s.load_value = mark_load(s.code[s.idx]);
        end
        return s;
    endfunction

    morse_state_e       state_q, state_d;
    logic [7:0]         code_q, code_d;
    logic [2:0]         idx_q, idx_d;

    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_load_value;
    logic [TIMER_W-1:0] tmr_value;
    logic               tmr_expire;
    logic               tmr_value_unused;

    logic               accept;
    logic               char_end;
    logic               start_go;
    morse_start_t       start_in;
    morse_start_t       start_sel;

`ifdef MORSE_TX_SKID_EN
    logic               hold_valid_q, hold_valid_d;
    logic [3:0]         hold_length_q, hold_length_d;
    logic [7:0]         hold_code_q, hold_code_d;
    logic               take_hold;
    logic               take_in;
    morse_start_t       start_hold;
`endif

    morse_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (tmr_load),
        .load_value (tmr_load_value),
        .value      (tmr_value),
        .expire     (tmr_expire)
    );

    // The sequencer only needs the expire flag; the count stays visible on
    // the timer for debug.
    assign tmr_value_unused = |tmr_value;

    assign accept   = in_valid && in_ready;
    assign char_end = (state_q == CGAP) && tmr_expire;
    assign start_in = start_char(in_length, in_code);

`ifdef MORSE_TX_SKID_EN
    // A held character always wins over the input port; a new character can
    // then refill the holding register in the same cycle.
    assign start_hold = start_char(hold_length_q, hold_code_q);
    assign take_hold  = hold_valid_q && ((state_q == IDLE) || char_end);
    assign in_ready   = !hold_valid_q || take_hold;
    assign take_in    = accept && !take_hold && ((state_q == IDLE) || char_end);
    assign start_go   = take_hold || take_in;
    assign start_sel  = take_hold ? start_hold : start_in;

    always_comb begin
        hold_valid_d  = hold_valid_q && !take_hold;
        hold_length_d = hold_length_q;
        hold_code_d   = hold_code_q;
        if (accept && !take_in) begin
            hold_valid_d  = 1'b1;
            hold_length_d = in_length;
            hold_code_d   = in_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q  <= 1'b0;
            hold_length_q <= 4'd0;
            hold_code_q   <= 8'd0;
        end else begin
            hold_valid_q  <= hold_valid_d;
            hold_length_q <= hold_length_d;
            hold_code_q   <= hold_code_d;
        end
    end
`else
    // in_ready is only high in IDLE, so an accept always starts a character.
    assign in_ready  = (state_q == IDLE);
    assign start_go  = accept;
    assign start_sel = start_in;
`endif

    always_comb begin
        state_d        = state_q;
        code_d         = code_q;
        idx_d          = idx_q;
        tmr_load       = 1'b0;
        tmr_load_value = '0;

        case (state_q)
            IDLE: begin
            end
            MARK: begin
                if (tmr_expire) begin
                    tmr_load = 1'b1;
                    if (idx_q != 3'd0) begin
                        state_d        = SPACE;
                        tmr_load_value = GAP_LD;
                    end else begin
                        state_d        = CGAP;
                        tmr_load_value = CHAR_GAP_LD;
                    end
                end
            end
            SPACE: begin
                if (tmr_expire) begin
                    state_d        = MARK;
                    idx_d          = idx_q - 3'd1;
                    tmr_load       = 1'b1;
                    tmr_load_value = mark_load(code_q[idx_q - 3'd1]);
                end
            end
            CGAP: begin
                if (tmr_expire) begin
                    state_d = IDLE;
                    code_d  = 8'd0;
                    idx_d   = 3'd0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Launching a character overrides the return to IDLE at the end of
        // a character gap, giving back-to-back characters.
        if (start_go) begin
            state_d        = start_sel.state;
            code_d         = start_sel.code;
            idx_d          = start_sel.idx;
            tmr_load       = 1'b1;
            tmr_load_value = start_sel.load_value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= 8'd0;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            idx_q   <= idx_d;
        end
    end

    assign morseout = (state_q == MARK);
    assign busy     = (state_q != IDLE);
    assign done     = char_end;

endmodule

// File: tb/tb_morse_tx.sv
// -----------------------------------------------------------------------------
// tb_morse_tx
//   Directed bench for morse_tx with CLK_KHZ=1, DOT=2, DASH=5, GAP=2,
//   CHAR_GAP=7 ms. Each accepted character pushes its cycle-by-cycle
//   expected morseout/done/busy onto a scoreboard queue; entries are popped
//   and compared one per clock. A small receiver decodes morseout back into
//   length/code, standing in for morseio on the loopback checks.
//   Build with MORSE_TX_SKID_EN defined to exercise the holding register.
// -----------------------------------------------------------------------------
module tb_morse_tx;

    localparam int CLK_KHZ     = 1;
    localparam int DOT_MS      = 2;
    localparam int DASH_MS     = 5;
    localparam int GAP_MS      = 2;
    localparam int CHAR_GAP_MS = 7;

    localparam int DOT_C      = DOT_MS * CLK_KHZ;
    localparam int DASH_C     = DASH_MS * CLK_KHZ;
    localparam int GAP_C      = GAP_MS * CLK_KHZ;
    localparam int CHAR_GAP_C = CHAR_GAP_MS * CLK_KHZ;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_length;
    logic [7:0] in_code;
    logic       morseout;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    morse_tx #(
        .CLK_KHZ     (CLK_KHZ),
        .DOT_MS      (DOT_MS),
        .DASH_MS     (DASH_MS),
        .GAP_MS      (GAP_MS),
        .CHAR_GAP_MS (CHAR_GAP_MS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_length (in_length),
        .in_code   (in_code),
        .morseout  (morseout),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic mo;
        logic dn;
        logic bz;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   fails  = 0;

    // Loopback receiver: a mark of 4+ cycles is a dash, shorter is a dot.
    int         dec_run   = 0;
    int         dec_cur_n = 0;
    logic [7:0] dec_cur_c = 8'd0;
    int         dec_len   = -1;
    logic [7:0] dec_code  = 8'd0;
    int         dec_count = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                dec_run   = 0;
                dec_cur_n = 0;
                dec_cur_c = 8'd0;
            end else begin
                if (morseout === 1'b1) begin
                    dec_run = dec_run + 1;
                end else if (dec_run > 0) begin
                    dec_cur_c = {dec_cur_c[6:0], (dec_run >= 4)};
                    dec_cur_n = dec_cur_n + 1;
                    dec_run   = 0;
                end
                if (done === 1'b1) begin
                    dec_len   = dec_cur_n;
                    dec_code  = dec_cur_c;
                    dec_count = dec_count + 1;
                    dec_cur_n = 0;
                    dec_cur_c = 8'd0;
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d fails=%0d", checks, fails);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_n(input int n, input logic mo, input logic last_done);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.mo = mo;
            e.bz = 1'b1;
            e.dn = last_done && (i == n - 1);
            sbq.push_back(e);
        end
    endtask

    task automatic push_char(input int len, input logic [7:0] code);
        int l;
        l = (len > 8) ? 8 : len;
        for (int i = l - 1; i >= 0; i--) begin
            push_n(code[i] ? DASH_C : DOT_C, 1'b1, 1'b0);
            if (i > 0) push_n(GAP_C, 1'b0, 1'b0);
        end
        push_n(CHAR_GAP_C, 1'b0, 1'b1);
    endtask

    task automatic check_cycle(input string tag);
        exp_t e;
        e = sbq.pop_front();
        chk({tag, " morseout"}, 8'(morseout), 8'(e.mo));
        chk({tag, " done"},     8'(done),     8'(e.dn));
        chk({tag, " busy"},     8'(busy),     8'(e.bz));
    endtask

    task automatic drain(input string tag);
        while (sbq.size() > 0) begin
            check_cycle(tag);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " morseout"}, 8'(morseout), 8'd0);
        chk({tag, " done"},     8'(done),     8'd0);
        chk({tag, " busy"},     8'(busy),     8'd0);
        chk({tag, " in_ready"}, 8'(in_ready), 8'd1);
    endtask

    task automatic send(input string tag, input logic [3:0] len, input logic [7:0] code);
        in_valid  = 1'b1;
        in_length = len;
        in_code   = code;
        chk({tag, " in_ready"}, 8'(in_ready), 8'd1);
        push_char(int'(len), code);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int n0;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_length = 4'd0;
        in_code   = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_idle("post_reset");

        // "A": dot dash, done 16 cycles after accept
        send("A", 4'd2, 8'h01);
        drain("A");
        check_idle("A_end");
        chk("A loop_len",  8'(dec_len), 8'd2);
        chk("A loop_code", dec_code,    8'h01);

        // word space
        n0 = dec_count;
        send("wspace", 4'd0, 8'h00);
        drain("wspace");
        check_idle("wspace_end");
        chk("wspace done_count", 8'(dec_count - n0), 8'd1);
        chk("wspace loop_len",   8'(dec_len),        8'd0);

        // length 12 clamps to 8 dashes
        send("len12", 4'd12, 8'hFF);
        drain("len12");
        check_idle("len12_end");
        chk("len12 loop_len",  8'(dec_len), 8'd8);
        chk("len12 loop_code", dec_code,    8'hFF);

        // bits above the length are ignored: dot dash dot
        send("mask", 4'd3, 8'hF2);
        drain("mask");
        chk("mask loop_len",  8'(dec_len), 8'd3);
        chk("mask loop_code", dec_code,    8'h02);

        // second character offered in the middle of "A"
        send("A2", 4'd2, 8'h01);
        for (int c = 0; c < 3; c++) begin
            check_cycle("A2");
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b1;
        in_length = 4'd1;
        in_code   = 8'h00;
`ifdef MORSE_TX_SKID_EN
        chk("skid in_ready", 8'(in_ready), 8'd1);
        push_char(1, 8'h00);
`else
        chk("noskid in_ready", 8'(in_ready), 8'd0);
`endif
        check_cycle("A2");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain("A2E");
        check_idle("A2E_end");
`ifdef MORSE_TX_SKID_EN
        chk("E loop_len",  8'(dec_len), 8'd1);
        chk("E loop_code", dec_code,    8'h00);
`else
        chk("A2 loop_len",  8'(dec_len), 8'd2);
        chk("A2 loop_code", dec_code,    8'h01);
`endif

        // reset during the dash of "A"
        n0 = dec_count;
        send("rstA", 4'd2, 8'h01);
        for (int c = 0; c < 6; c++) begin
            check_cycle("rstA");
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        check_cycle("rstA");
        @(posedge clk);
        #1;
        sbq.delete();
        chk("rst morseout", 8'(morseout), 8'd0);
        chk("rst done",     8'(done),     8'd0);
        chk("rst busy",     8'(busy),     8'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_idle("after_rst");
        for (int c = 0; c < 10; c++) begin
            chk("after_rst done",     8'(done),     8'd0);
            chk("after_rst morseout", 8'(morseout), 8'd0);
            @(posedge clk);
            #1;
        end
        chk("rst no_done", 8'(dec_count - n0), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/morse_tx.md
MORSE_TX -- requirements
Module: morse_tx

Interface
REQ-001 SHALL have parameter CLK_KHZ, default 10, clk frequency in kHz.
REQ-002 SHALL have parameter DOT_MS, default 100, mark time of a dot in ms.
REQ-003 SHALL have parameter DASH_MS, default 400, mark time of a dash in ms.
REQ-004 SHALL have parameter GAP_MS, default 100, space between elements of one character in ms.
REQ-005 SHALL have parameter CHAR_GAP_MS, default 700, space after the last element of a character in ms.
REQ-006 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port in_valid  input  1  character offered.
REQ-009 SHALL have port in_ready  output  1  character can be accepted this cycle.
REQ-010 SHALL have port in_length  input  4  number of elements, 0..15.
REQ-011 SHALL have port in_code  input  8  elements, 0=dot, 1=dash; first element at bit in_length-1, last at bit 0.
REQ-012 SHALL have port morseout  output  1  keyed line, 1=mark.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse at the end of each character's gap.

Function
REQ-015 SHALL accept a character on the cycle in_valid && in_ready and register in_code/in_length.
REQ-016 SHALL convert ms to cycles as X_CYC = X_MS*CLK_KHZ, each at least 1.
REQ-017 SHALL use states IDLE, MARK, SPACE, CGAP.
REQ-018 SHALL move IDLE->MARK on accept with in_length>=1; morseout=1 from the next cycle.
REQ-019 SHALL hold MARK for exactly DOT_CYC (bit=0) or DASH_CYC (bit=1) cycles, then go to SPACE if elements remain, else to CGAP.
REQ-020 SHALL hold SPACE (morseout=0) for exactly GAP_CYC cycles, then return to MARK with the next lower bit.
REQ-021 SHALL hold CGAP (morseout=0) for exactly CHAR_GAP_CYC cycles, pulse done on its last cycle, then go to IDLE.
REQ-022 SHALL treat in_length=0 as a word space: IDLE->CGAP directly, no mark, done pulsed as usual.
REQ-023 SHALL clamp in_length>8 to 8.
REQ-024 SHALL ignore in_code bits at or above the clamped length.
REQ-025 SHALL drive in_ready=1 only in IDLE, unless MORSE_TX_SKID_EN is defined.
REQ-026 SHALL hold morseout=0 in IDLE, SPACE and CGAP.

Reset
REQ-027 SHALL, on rst, force state IDLE, morseout=0, done=0, busy=0, clear timer and registered character, and abort any character in flight with no done pulse.
REQ-028 SHALL drive in_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-029 SHALL, with MORSE_TX_SKID_EN defined, add a one-entry holding register and drive in_ready=1 whenever that register is empty, including mid-character.
REQ-030 SHALL, with MORSE_TX_SKID_EN defined, go from CGAP's last cycle directly to MARK (or CGAP for length 0) of the held character with no idle cycle.
REQ-031 SHALL, with MORSE_TX_SKID_EN defined, accept a new character in the same cycle the held one is consumed.
REQ-032 SHALL, without MORSE_TX_SKID_EN, contain no holding register and keep in_ready=0 outside IDLE.

Structure
REQ-033 SHALL place the state enum, the default timing constants and the ms-to-cycles conversion in shared package morse_pkg, also used by morseio.
REQ-034 SHALL instantiate one sub-module morse_timer, a loadable 32-bit down-counter with load, value and expire outputs.

Verification
REQ-035 SHALL use bench parameters CLK_KHZ=1, DOT=2, DASH=5, GAP=2, CHAR_GAP=7 ms.
REQ-036 SHALL check: code=8'h01, length=2 ("A") -> morseout 1 for 2, 0 for 2, 1 for 5, 0 for 7 cycles; done on cycle 16 after accept.
REQ-037 SHALL check: length=0 -> morseout stays 0, busy 7 cycles, done once.
REQ-038 SHALL check: length=12, code=8'hFF -> exactly 8 dashes.
REQ-039 SHALL check: rst during the second mark of "A" -> morseout=0 the next cycle, no done, in_ready=1 after rst deasserts.
REQ-040 SHALL check, with SKID_EN: offer "E" (len 1, code 0) during "A" -> accepted mid-character; first "E" mark on the cycle after "A"'s done.
REQ-041 SHALL check: loopback into morseio -> "A" decoded as morse_length=2, morse_input=8'h01.
